fp_div_iterative: RTL and testbench
===================================

// Module: fp_div_iterative
// PURPOSE
//  Multi-cycle IEEE-754-style floating-point divider (result = op_a / op_b) with parametrised exponent/mantissa widths.
//  Uses a restoring radix-2 quotient loop and round-to-nearest-even, with full special-case and exception-flag handling.
//  Sits beside the combinational FP ALU as its divide path, behind a valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8    exponent field width; BIAS = 2**(EXP_W-1)-1 (localparam)
//  MAN_W   23   stored fraction width; operand width W = 1+EXP_W+MAN_W; Q_BITS = MAN_W+3 (localparam)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  flush      in   1      synchronous abort of any in-flight op
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept; =1 iff state==IDLE
//  op_a       in   W      dividend {sign, exp, frac}
//  op_b       in   W      divisor
//  out_valid  out  1      result/flags valid; =1 iff state==DONE
//  out_ready  in   1      consumer accepts result
//  result     out  W      quotient
//  flags      out  5      {invalid, div_by_zero, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, flags=0; in_ready=1 (IDLE). Reset mid-op discards it.
//  FSM: IDLE -> CALC (normal op) | DONE (special case) on in_valid&in_ready; CALC -> ROUND after Q_BITS cycles; ROUND -> DONE; DONE -> IDLE on out_ready.
//  flush has priority over all transitions: next state IDLE, out_valid=0 next cycle, no result emitted.
//  Latency from accept edge: normal Q_BITS+2 cycles (28 at defaults); special case 1 cycle. One bubble between ops.
//  DONE: result/flags held stable while out_valid & !out_ready. Operands are registered at accept; later in_* changes are ignored.
//  Classify: exp==0 -> zero (subnormal inputs treated as zero, sign kept); exp all-ones: frac==0 inf, else NaN (sNaN if frac MSB=0).
//  Special results (sign = sa^sb unless NaN):
//   any NaN -> qNaN {0,1..1,1,0..0}, invalid iff an sNaN; 0/0 or inf/inf -> qNaN, invalid
//   inf/finite -> ±inf; finite/inf -> ±0; 0/nonzero -> ±0; nonzero-finite/0 -> ±inf, div_by_zero
//  CALC: R init = {1,frac_a} (MAN_W+2 bits), D={1,frac_b}; per cycle, q bit (MSB first) = (R>=D); if set R-=D; then R<<=1.
//  ROUND: if q[Q_BITS-1]: sig=q[Q_BITS-1:2], g=q[1], s=q[0]|(R!=0);
//   else sig=q[Q_BITS-2:1], g=q[0], s=(R!=0), exponent -1.
//   e = ea - eb + BIAS (signed, EXP_W+2 bits) with the adjustment above; round_up = g&(s|sig[0]); carry out of sig -> sig>>1, e+1.
//   inexact = g|s. After rounding: e >= 2**EXP_W-1 -> ±inf, overflow|inexact; e <= 0 -> ±0 (flush, no subnormals), underflow|inexact.
//  Flags cleared on each accept; only the current op's flags are reported.
// TESTING
//  1 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
//  2 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flags 5'b00001 (normalise-shift path plus round-up).
//  3 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero, 1-cycle latency; 0/0 -> 0x7FC00000, invalid; 0x7F800001 / 1.0 -> 0x7FC00000, invalid.
//  4 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow|inexact; 0x00800000 / 0x40000000 -> 0x00000000, underflow|inexact.
//  5 Hold out_ready=0 for 10 cycles: result/flags stable, in_ready=0. Flush at CALC cycle 10: no out_valid, in_ready next cycle, next op correct. rst_n low mid-CALC: all outputs at reset values.
//  6 EXP_W=5, MAN_W=10: 0x4600 / 0x4000 -> 0x4200, latency 15; 0x3C00 / 0x4200 -> 0x3555, inexact.

Source files
------------

// File: rtl/fp_div_iterative.sv
// rtl/fp_div_iterative.sv - multi-cycle restoring radix-2 floating-point divider
module fp_div_iterative #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int Q_BITS = MAN_W + 3;
    localparam int EW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(Q_BITS);

    localparam logic [EW-1:0]    BIAS_E    = EW'(BIAS);
    localparam logic [EW-1:0]    EXP_MAX_E = EW'(2**EXP_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(Q_BITS - 1);
    localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Operand fields
    logic             sa, sb, sign_q;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             accept;

    // Special-case result
    logic             spec_hit;
    logic [W-1:0]     spec_res;
    logic [4:0]       spec_flags;
    logic [EW-1:0]    exp_init;

    // Iteration state
    logic             sign_r;
    logic [EW-1:0]    exp_r;
    logic [MAN_W+1:0] rem_r;
    logic [MAN_W:0]   div_r;
    logic [Q_BITS-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     result_r;
    logic [4:0]       flags_r;

    // Iteration step
    logic             q_bit;
    logic [MAN_W:0]   rem_keep;
    logic [MAN_W+1:0] rem_next;

    // Rounding
    logic             norm, rem_nz, g, s, round_up;
    logic [MAN_W:0]   sig_pre;
    logic [MAN_W+1:0] sig_sum;
    logic [MAN_W-1:0] frac_fin;
    logic [EW-1:0]    e_adj, e_fin;
    logic [W-1:0]     rnd_res;
    logic [4:0]       rnd_flags;

    assign sa     = op_a[W-1];
    assign sb     = op_b[W-1];
    assign ea     = op_a[W-2:MAN_W];
    assign eb     = op_b[W-2:MAN_W];
    assign fa     = op_a[MAN_W-1:0];
    assign fb     = op_b[MAN_W-1:0];
    assign sign_q = sa ^ sb;

    // Subnormal inputs have exp==0 and are treated as signed zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_r;
    assign flags     = flags_r;

    // Biased exponent of the quotient before normalisation; wide enough to go negative.
    assign exp_init = {2'b00, ea} - {2'b00, eb} + BIAS_E;

    // Special-case detection: these bypass the quotient loop entirely.
    always_comb begin
        spec_hit   = 1'b0;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_hit      = 1'b1;
            spec_res      = QNAN;
            spec_flags[4] = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_hit      = 1'b1;
            spec_res      = QNAN;
            spec_flags[4] = 1'b1;
        end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_hit = 1'b1;
            spec_res = {sign_q, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_hit      = 1'b1;
            spec_res      = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags[3] = 1'b1;
        end
    end

    // One restoring step: subtract when the partial remainder covers the divisor, then shift.
    always_comb begin
        q_bit    = (rem_r >= {1'b0, div_r});
        rem_keep = q_bit ? (rem_r[MAN_W:0] - div_r) : rem_r[MAN_W:0];
        rem_next = {rem_keep, 1'b0};
    end

    // Normalise, round to nearest even and detect overflow/underflow.
    always_comb begin
        norm   = q_r[Q_BITS-1];
        rem_nz = |rem_r;
        if (norm) begin
            sig_pre = q_r[Q_BITS-1:2];
            g       = q_r[1];
            s       = q_r[0] | rem_nz;
            e_adj   = exp_r;
        end else begin
            sig_pre = q_r[Q_BITS-2:1];
            g       = q_r[0];
            s       = rem_nz;
            e_adj   = exp_r - EW'(1);
        end
        round_up = g & (s | sig_pre[0]);
        sig_sum  = {1'b0, sig_pre} + {{(MAN_W+1){1'b0}}, round_up};
        if (sig_sum[MAN_W+1]) begin
            frac_fin = sig_sum[MAN_W:1];
            e_fin    = e_adj + EW'(1);
        end else begin
            frac_fin = sig_sum[MAN_W-1:0];
            e_fin    = e_adj;
        end
        rnd_res   = {sign_r, e_fin[EXP_W-1:0], frac_fin};
        rnd_flags = {4'b0000, g | s};
        if ($signed(e_fin) >= $signed(EXP_MAX_E)) begin
            rnd_res   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags = 5'b00101;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            rnd_res   = {sign_r, {(W-1){1'b0}}};
            rnd_flags = 5'b00011;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = spec_hit ? S_DONE : S_CALC;
            S_CALC:  if (cnt_r == CNT_LAST) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: capture operands at accept, iterate in CALC, commit the rounded result in ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            exp_r    <= '0;
            rem_r    <= '0;
            div_r    <= '0;
            q_r      <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            flags_r  <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_r  <= sign_q;
                        exp_r   <= exp_init;
                        rem_r   <= {2'b01, fa};
                        div_r   <= {1'b1, fb};
                        q_r     <= '0;
                        cnt_r   <= '0;
                        flags_r <= spec_flags;
                        if (spec_hit) begin
                            result_r <= spec_res;
                        end
                    end
                end
                S_CALC: begin
                    q_r   <= {q_r[Q_BITS-2:0], q_bit};
                    rem_r <= rem_next;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                S_ROUND: begin
                    result_r <= rnd_res;
                    flags_r  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iterative.sv
// tb/tb_fp_div_iterative.sv - self-checking bench for fp_div_iterative
module tb_fp_div_iterative;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready, in_ready, out_valid;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  flags;

    logic        flush_h, in_valid_h, out_ready_h, in_ready_h, out_valid_h;
    logic [15:0] op_a_h, op_b_h, result_h;
    logic [4:0]  flags_h;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
    } exp_h_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    exp_t   sb[$];
    exp_h_t sb_h[$];
    vec_t   vecs[$];

    always #5 clk = ~clk;

    fp_div_iterative #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_div_iterative #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .flush(flush_h),
        .in_valid(in_valid_h), .in_ready(in_ready_h),
        .op_a(op_a_h), .op_b(op_b_h),
        .out_valid(out_valid_h), .out_ready(out_ready_h),
        .result(result_h), .flags(flags_h)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [4:0] f, input int lat);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.res = res; v.flg = f; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] f);
        exp_t e;
        e.res = res; e.flg = f;
        sb.push_back(e);
    endtask

    task automatic drive_accept(input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_result(input string nm, input int lat, input int hold);
        int   cnt = 1;
        logic stable = 1'b1;
        logic [31:0] r0;
        logic [4:0]  f0;
        exp_t e;
        @(negedge clk);
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_valid"}, out_valid, 1);
        if (lat > 0) check({nm, "_latency"}, cnt, lat);
        if (hold > 0) begin
            r0 = result; f0 = flags;
            repeat (hold) begin
                @(negedge clk);
                if (result !== r0 || flags !== f0 || !out_valid || in_ready) stable = 1'b0;
            end
            check({nm, "_hold_stable"}, stable, 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({nm, "_result"}, result, e.res);
            check({nm, "_flags"}, flags, e.flg);
        end else begin
            n_checks++;
            $display("FAIL %s_scoreboard: got output, expected none pending", nm);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_h(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [4:0] f, input int lat);
        int g = 0;
        int cnt = 1;
        exp_h_t e;
        e.res = res; e.flg = f;
        sb_h.push_back(e);
        while (!in_ready_h && g < 100) begin
            @(negedge clk);
            g++;
        end
        in_valid_h = 1'b1; op_a_h = a; op_b_h = b;
        @(posedge clk);
        #1;
        in_valid_h = 1'b0; op_a_h = '0; op_b_h = '0;
        @(negedge clk);
        while (!out_valid_h && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_valid"}, out_valid_h, 1);
        check({nm, "_latency"}, cnt, lat);
        e = sb_h.pop_front();
        check({nm, "_result"}, result_h, e.res);
        check({nm, "_flags"}, flags_h, e.flg);
        out_ready_h = 1'b1;
        @(posedge clk);
        #1;
        out_ready_h = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0;
        flush_h = 1'b0; in_valid_h = 1'b0; out_ready_h = 1'b0;
        op_a_h = '0; op_b_h = '0;

        add_vec("div_6_2",      32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
        add_vec("div_1_3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
        add_vec("div_m6_2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28);
        add_vec("div_2_3",      32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 28);
        add_vec("div_1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28);
        add_vec("div_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
        add_vec("zero_zero",    32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
        add_vec("snan_a",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
        add_vec("qnan_a",       32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
        add_vec("inf_inf",      32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1);
        add_vec("ninf_fin",     32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
        add_vec("fin_ninf",     32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 1);
        add_vec("zero_neg",     32'h00000000, 32'hC0A00000, 32'h80000000, 5'b00000, 1);
        add_vec("subn_zero",    32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);
        add_vec("neg_by_nzero", 32'hBF800000, 32'h80000000, 32'h7F800000, 5'b01000, 1);
        add_vec("inf_by_zero",  32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1);
        add_vec("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28);
        add_vec("max_exp",      32'h7F000000, 32'h3F800000, 32'h7F000000, 5'b00000, 28);
        add_vec("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);
        add_vec("min_normal",   32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000, 28);

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            push_exp(vecs[i].res, vecs[i].flg);
            drive_accept(vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, vecs[i].lat, 0);
        end

        // Back-pressure: result held for 10 cycles with out_ready low.
        push_exp(32'h40400000, 5'b00000);
        drive_accept(32'h40C00000, 32'h40000000);
        wait_result("hold", 28, 10);

        // Flush in the tenth CALC cycle: nothing must come out.
        drive_accept(32'h40C00000, 32'h40000000);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_no_result", seen, 0);
        push_exp(32'h3EAAAAAB, 5'b00001);
        drive_accept(32'h3F800000, 32'h40400000);
        wait_result("after_flush", 28, 0);

        // Asynchronous reset in the middle of CALC.
        drive_accept(32'h40C00000, 32'h40000000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_result", result, 0);
        check("midreset_flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(32'h40400000, 5'b00000);
        drive_accept(32'h40C00000, 32'h40000000);
        wait_result("after_reset", 28, 0);

        // Half-precision instance.
        run_h("h_6_2", 16'h4600, 16'h4000, 16'h4200, 5'b00000, 15);
        run_h("h_1_3", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15);
        run_h("h_1_0", 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
